// File: rtl/lvg_dripper.sv
// lvg_dripper -- skew feeder for the 4x4 systolic array.
//
// Captures a 4x4 matrix of W-bit words in a single cycle, then replays it as
// a diagonal wavefront selected by the externally supplied step index.
// Lane k (1-based) carries column k, delayed k-1 steps relative to lane 1.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset (clears matrix and lanes)
//   i11..i44         matrix element inputs, row r / column c as i{r}{c}
//   count            drip step index, meaningful values 1..7
//   load             capture strobe; overrides count for that cycle
//   p1..p4           registered lane outputs, one cycle after count/load
module lvg_dripper #(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i11, i12, i13, i14,
  input  logic [W-1:0] i21, i22, i23, i24,
  input  logic [W-1:0] i31, i32, i33, i34,
  input  logic [W-1:0] i41, i42, i43, i44,
  input  logic [5:0]   count,
  input  logic         load,
  output logic [W-1:0] p1,
  output logic [W-1:0] p2,
  output logic [W-1:0] p3,
  output logic [W-1:0] p4
);

  // Flattened view of the matrix inputs, indexed [row][col] from 0.
  logic [W-1:0] in_mat [N][N];

  assign in_mat[0][0] = i11; assign in_mat[0][1] = i12;
  assign in_mat[0][2] = i13; assign in_mat[0][3] = i14;
  assign in_mat[1][0] = i21; assign in_mat[1][1] = i22;
  assign in_mat[1][2] = i23; assign in_mat[1][3] = i24;
  assign in_mat[2][0] = i31; assign in_mat[2][1] = i32;
  assign in_mat[2][2] = i33; assign in_mat[2][3] = i34;
  assign in_mat[3][0] = i41; assign in_mat[3][1] = i42;
  assign in_mat[3][2] = i43; assign in_mat[3][3] = i44;

  // Stored matrix. All 16 words are read in parallel every cycle, so this
  // is plain register storage rather than a RAM.
  logic [W-1:0] m_reg [N][N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          m_reg[r][c] <= '0;
        end
      end
    end else if (load) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          m_reg[r][c] <= in_mat[r][c];
        end
      end
    end
  end

  // Lane registers, 0-based lane index.
  logic [W-1:0] lane_reg [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [W-1:0] lane_next;

      // Lane gi (column gi) shows row rr when count == gi + rr + 1.
      // Matching the full 6-bit count against each legal step means any
      // out-of-range count (0, >= 8, or outside this lane's window) falls
      // through to zero with no wrap-around aliasing.
      always_comb begin
        lane_next = '0;
        for (int rr = 0; rr < N; rr++) begin
          if (count == 6'(gi + rr + 1)) begin
            lane_next = m_reg[rr][gi];
          end
        end
      end

      // Load blanks the lanes for its cycle; the freshly captured matrix is
      // only visible from the following cycle, so nothing mixes old/new data.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lane_reg[gi] <= '0;
        end else if (load) begin
          lane_reg[gi] <= '0;
        end else begin
          lane_reg[gi] <= lane_next;
        end
      end
    end
  endgenerate

  assign p1 = lane_reg[0];
  assign p2 = lane_reg[1];
  assign p3 = lane_reg[2];
  assign p4 = lane_reg[3];

endmodule

// File: tb/tb_lvg_dripper.sv
// Directed testbench for lvg_dripper: hand-computed expected lane values for
// reset, identity and full-ordering drips, out-of-range steps, load priority
// and matrix hold.
module tb_lvg_dripper;

  logic        clk;
  logic        rst;
  logic [31:0] mat [4][4];
  logic [5:0]  count;
  logic        load;
  logic [31:0] p1, p2, p3, p4;

  int total;
  int bad;

  lvg_dripper dut (
    .clk   (clk),
    .rst   (rst),
    .i11   (mat[0][0]), .i12 (mat[0][1]), .i13 (mat[0][2]), .i14 (mat[0][3]),
    .i21   (mat[1][0]), .i22 (mat[1][1]), .i23 (mat[1][2]), .i24 (mat[1][3]),
    .i31   (mat[2][0]), .i32 (mat[2][1]), .i33 (mat[2][2]), .i34 (mat[2][3]),
    .i41   (mat[3][0]), .i42 (mat[3][1]), .i43 (mat[3][2]), .i44 (mat[3][3]),
    .count (count),
    .load  (load),
    .p1    (p1),
    .p2    (p2),
    .p3    (p3),
    .p4    (p4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic check_lanes(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                             input logic [31:0] e3, input logic [31:0] e4);
    check({tag, ".p1"}, p1, e1);
    check({tag, ".p2"}, p2, e2);
    check({tag, ".p3"}, p3, e3);
    check({tag, ".p4"}, p4, e4);
  endtask

  // Present count/load, take one rising edge, sample 1 time unit later.
  task automatic step(input logic [5:0] c, input logic l);
    count = c;
    load  = l;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic fill_ordered();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        mat[r][c] = 32'((r + 1) * 16 + (c + 1));
  endtask

  task automatic fill_const(input logic [31:0] v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        mat[r][c] = v;
  endtask

  logic [31:0] e1, e2, e3, e4;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    count = '0;
    load  = 1'b0;
    fill_const(32'h0);

    #12;
    check_lanes("reset_state", 32'h0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-drip: load ordered matrix, drip step 4, then assert rst between edges.
    fill_ordered();
    step(6'd0, 1'b1);
    step(6'd4, 1'b0);
    check_lanes("pre_rst_c4", 32'h41, 32'h32, 32'h23, 32'h14);
    #2 rst = 1'b1;
    #1 check_lanes("async_rst", 32'h0, 32'h0, 32'h0, 32'h0);
    #1 rst = 1'b0;
    step(6'd3, 1'b0);
    check_lanes("post_rst_c3", 32'h0, 32'h0, 32'h0, 32'h0);

    // Identity drip: each lane shows 0000ffff only at step 2k-1.
    fill_const(32'h0);
    for (int k = 0; k < 4; k++) mat[k][k] = 32'h0000ffff;
    step(6'd0, 1'b1);
    check_lanes("ident_load", 32'h0, 32'h0, 32'h0, 32'h0);
    for (int n = 1; n <= 7; n++) begin
      step(6'(n), 1'b0);
      e1 = (n == 1) ? 32'h0000ffff : 32'h0;
      e2 = (n == 3) ? 32'h0000ffff : 32'h0;
      e3 = (n == 5) ? 32'h0000ffff : 32'h0;
      e4 = (n == 7) ? 32'h0000ffff : 32'h0;
      check_lanes($sformatf("ident_c%0d", n), e1, e2, e3, e4);
    end

    // Full ordering.
    fill_ordered();
    step(6'd0, 1'b1);
    step(6'd1, 1'b0);
    check_lanes("ord_c1", 32'h11, 32'h0, 32'h0, 32'h0);
    step(6'd2, 1'b0);
    check_lanes("ord_c2", 32'h21, 32'h12, 32'h0, 32'h0);
    step(6'd4, 1'b0);
    check_lanes("ord_c4", 32'h41, 32'h32, 32'h23, 32'h14);
    step(6'd6, 1'b0);
    check_lanes("ord_c6", 32'h0, 32'h0, 32'h43, 32'h34);
    step(6'd7, 1'b0);
    check_lanes("ord_c7", 32'h0, 32'h0, 32'h0, 32'h44);
    // Non-monotonic and repeated counts.
    step(6'd3, 1'b0);
    check_lanes("ord_c3", 32'h31, 32'h22, 32'h13, 32'h0);
    step(6'd5, 1'b0);
    check_lanes("ord_c5", 32'h0, 32'h42, 32'h33, 32'h24);
    step(6'd5, 1'b0);
    check_lanes("ord_c5_rep", 32'h0, 32'h42, 32'h33, 32'h24);

    // Out of range.
    step(6'd0, 1'b0);
    check_lanes("oor_c0", 32'h0, 32'h0, 32'h0, 32'h0);
    step(6'd8, 1'b0);
    check_lanes("oor_c8", 32'h0, 32'h0, 32'h0, 32'h0);
    step(6'd63, 1'b0);
    check_lanes("oor_c63", 32'h0, 32'h0, 32'h0, 32'h0);
    step(6'd12, 1'b0);
    check_lanes("oor_c12", 32'h0, 32'h0, 32'h0, 32'h0);

    // Load priority: count ignored on the load cycle, new data next cycle.
    fill_const(32'h0000aaaa);
    step(6'd4, 1'b1);
    check_lanes("ldpri_load", 32'h0, 32'h0, 32'h0, 32'h0);
    step(6'd4, 1'b0);
    check_lanes("ldpri_c4", 32'h0000aaaa, 32'h0000aaaa, 32'h0000aaaa, 32'h0000aaaa);

    // Hold: matrix survives idle cycles.
    fill_ordered();
    mat[0][0] = 32'h12345678;
    step(6'd0, 1'b1);
    fill_const(32'hdeadbeef);
    for (int i = 0; i < 10; i++) step(6'd0, 1'b0);
    step(6'd1, 1'b0);
    check_lanes("hold_c1", 32'h12345678, 32'h0, 32'h0, 32'h0);
    step(6'd7, 1'b0);
    check_lanes("hold_c7", 32'h0, 32'h0, 32'h0, 32'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
